// File: rtl/lms_adaptive_fir.sv
// N-tap LMS adaptive FIR: two-stage sample pipeline, round-and-saturate
// fixed-point datapath, three adaptation modes, weight write/readback port
// and a sticky saturation flag.

// Per-tap adaptation: computes the saturated next weight for one tap and
// reports whether any clamp fired along the way.
module lms_tap #(
  parameter int DW   = 16,
  parameter int FRAC = 12
) (
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] w_i,
  input  logic signed [DW-1:0] ec_i,
  input  logic signed [DW-1:0] gamma_i,
  input  logic        [1:0]    mode_i,
  output logic signed [DW-1:0] w_nxt_o,
  output logic                 sat_o
);
  localparam int WW = 2*DW+2;
  localparam logic signed [WW-1:0] MAXV = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [WW-1:0] RND  = {{(WW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  function automatic logic signed [WW-1:0] sx(input logic signed [DW-1:0] a);
    return {{(WW-DW){a[DW-1]}}, a};
  endfunction
  function automatic logic ovf(input logic signed [WW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction
  function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > MAXV) return {1'b0, {(DW-1){1'b1}}};
    if (v < MINV) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  logic signed [WW-1:0] t_p, t_u0, t_g, t_n, t_s;
  logic signed [DW-1:0] p, g, u;
  logic                 sat_u;

  // update term per mode, then saturating accumulate into the weight
  always_comb begin
    t_p   = (sx(ec_i) * sx(x_i) + RND) >>> FRAC;
    p     = sat(t_p);
    t_u0  = (sx(gamma_i) * sx(p) + RND) >>> FRAC;
    t_g   = (sx(gamma_i) * sx(x_i) + RND) >>> FRAC;
    g     = sat(t_g);
    t_n   = '0;
    u     = '0;
    sat_u = 1'b0;
    case (mode_i)
      2'd0: begin
        u     = sat(t_u0);
        sat_u = ovf(t_p) | ovf(t_u0);
      end
      2'd1: if (ec_i != '0) begin
        t_n   = ec_i[DW-1] ? -sx(g) : sx(g);
        u     = sat(t_n);
        sat_u = ovf(t_g) | ovf(t_n);
      end
      2'd2: if (ec_i != '0 && x_i != '0) begin
        t_n   = (ec_i[DW-1] == x_i[DW-1]) ? sx(gamma_i) : -sx(gamma_i);
        u     = sat(t_n);
        sat_u = ovf(t_n);
      end
      default: ;
    endcase
    t_s     = sx(w_i) + sx(u);
    w_nxt_o = sat(t_s);
    sat_o   = sat_u | ovf(t_s);
  end
endmodule

module lms_adaptive_fir #(
  parameter int N_TAPS = 8,
  parameter int DW     = 16,
  parameter int FRAC   = 12,
  parameter int AW     = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] d_in,
  input  logic                 training_en,
  input  logic        [1:0]    mode,
  input  logic signed [DW-1:0] gamma,
  input  logic                 w_wr_en,
  input  logic        [AW-1:0] w_wr_addr,
  input  logic signed [DW-1:0] w_wr_data,
  input  logic        [AW-1:0] w_rd_addr,
  output logic signed [DW-1:0] w_rd_data,
  output logic                 m_valid,
  output logic signed [DW-1:0] y_out,
  output logic signed [DW-1:0] err,
  output logic                 sat_flag,
  input  logic                 sat_clr
);
  localparam int WW = 2*DW+AW+2;
  localparam logic signed [WW-1:0] MAXV = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [WW-1:0] RND  = {{(WW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  function automatic logic signed [WW-1:0] sx(input logic signed [DW-1:0] a);
    return {{(WW-DW){a[DW-1]}}, a};
  endfunction
  function automatic logic ovf(input logic signed [WW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction
  function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > MAXV) return {1'b0, {(DW-1){1'b1}}};
    if (v < MINV) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  logic [N_TAPS-1:0][DW-1:0] x_q, x_d, w_q, w_d, w_nxt;
  logic [N_TAPS-1:0]         tap_sat, wr_hit;
  logic signed [DW-1:0]      d_q, d_d, y_q, y_d, e_q, e_d, yc, ec;
  logic                      v1_q, v1_d, mv_q, mv_d, sat_q, sat_d;
  logic                      ysat, esat, upd_en, sat_ev;
  logic signed [WW-1:0]      acc, t_y, t_e;

  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    lms_tap #(.DW(DW), .FRAC(FRAC)) u_tap (
      .x_i(x_q[i]), .w_i(w_q[i]), .ec_i(ec), .gamma_i(gamma), .mode_i(mode),
      .w_nxt_o(w_nxt[i]), .sat_o(tap_sat[i])
    );
  end

  // stage 2: dot product, rounded/saturated output and error
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) acc = acc + sx(w_q[i]) * sx(x_q[i]);
    t_y  = (acc + RND) >>> FRAC;
    yc   = sat(t_y);
    ysat = ovf(t_y);
    t_e  = sx(d_q) - sx(yc);
    ec   = sat(t_e);
    esat = ovf(t_e);
  end

  // next state: tap shift, output capture, weight update/write, sticky flag
  always_comb begin
    x_d    = x_q;
    d_d    = d_q;
    v1_d   = s_valid;
    if (s_valid) begin
      x_d = {x_q[N_TAPS-2:0], x_in};
      d_d = d_in;
    end
    upd_en = v1_q & training_en & (mode != 2'd3);
    wr_hit = '0;
    w_d    = w_q;
    for (int i = 0; i < N_TAPS; i++) begin
      wr_hit[i] = w_wr_en && (w_wr_addr == AW'(i));
      if (wr_hit[i])  w_d[i] = w_wr_data;
      else if (upd_en) w_d[i] = w_nxt[i];
    end
    // a clamp in a weight overwritten by the host port is never consumed
    sat_ev = v1_q & (ysat | esat | (upd_en & |(tap_sat & ~wr_hit)));
    mv_d   = v1_q;
    y_d    = v1_q ? yc : y_q;
    e_d    = v1_q ? ec : e_q;
    sat_d  = sat_clr ? 1'b0 : sat_q;
    if (sat_ev) sat_d = 1'b1;
  end

  // pipeline and weight registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x_q <= '0; d_q <= '0; v1_q <= 1'b0; w_q <= '0;
      mv_q <= 1'b0; y_q <= '0; e_q <= '0; sat_q <= 1'b0;
    end else begin
      x_q <= x_d; d_q <= d_d; v1_q <= v1_d; w_q <= w_d;
      mv_q <= mv_d; y_q <= y_d; e_q <= e_d; sat_q <= sat_d;
    end
  end

  // readback mux; unmapped indices read as zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_TAPS; i++)
      if (w_rd_addr == AW'(i)) w_rd_data = w_q[i];
  end

  assign m_valid  = mv_q;
  assign y_out    = y_q;
  assign err      = e_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_lms_adaptive_fir.sv
// Self-checking bench for lms_adaptive_fir: vector table for the static
// filter plus directed sequences for adaptation, saturation, collision and
// mid-stream reset. Expected outputs go to a queue when samples are driven.
module tb_lms_adaptive_fir;
  localparam int N = 8, DW = 16, AW = 3;

  logic Clk = 1'b0, Rst = 1'b1, s_valid = 1'b0, training_en = 1'b0;
  logic w_wr_en = 1'b0, sat_clr = 1'b0;
  logic signed [DW-1:0] x_in = '0, d_in = '0, gamma = '0, w_wr_data = '0;
  logic [1:0] mode = '0;
  logic [AW-1:0] w_wr_addr = '0, w_rd_addr = '0;
  logic signed [DW-1:0] w_rd_data, y_out, err;
  logic m_valid, sat_flag;

  always #5 Clk = ~Clk;

  lms_adaptive_fir #(.N_TAPS(N), .DW(DW), .FRAC(12), .AW(AW)) dut (
    .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .x_in(x_in), .d_in(d_in),
    .training_en(training_en), .mode(mode), .gamma(gamma),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .m_valid(m_valid),
    .y_out(y_out), .err(err), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  typedef struct { logic sv; int x; int d; int ey; int ee; } vec_t;
  typedef struct { int y; int e; } exp_t;
  exp_t sbq[$];
  vec_t tbl[9];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // one clock: edge, then sample outputs on the falling edge
  task automatic step();
    exp_t e;
    @(posedge Clk);
    @(negedge Clk);
    if (m_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output y=%0d err=%0d", y_out, err);
      end else begin
        e = sbq.pop_front();
        chk("y_out", int'(y_out), e.y);
        chk("err", int'(err), e.e);
      end
    end
  endtask

  task automatic drive(input logic sv, input int x, input int d, input int ey, input int ee);
    exp_t e;
    s_valid = sv;
    x_in = DW'(x);
    d_in = DW'(d);
    if (sv) begin
      e.y = ey; e.e = ee;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int i = 0; i < 8 && sbq.size() != 0; i++) step();
    chk("pending_outputs", sbq.size(), 0);
  endtask

  task automatic wr(input int a, input int d);
    w_wr_en = 1'b1; w_wr_addr = AW'(a); w_wr_data = DW'(d);
    step();
    w_wr_en = 1'b0;
  endtask

  task automatic rdchk(input string nm, input int a, input int exp);
    w_rd_addr = AW'(a);
    #1;
    chk(nm, int'(w_rd_data), exp);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    s_valid = 1'b0;
    sbq.delete();
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    // weights w0=1.0, w1=0.5, no adaptation: y = x[0] + x[1]/2
    tbl[0] = '{1'b1, 4096,     0, 4096, -4096};
    tbl[1] = '{1'b1, 4096,     0, 6144, -6144};
    tbl[2] = '{1'b1,    0,     0, 2048, -2048};
    tbl[3] = '{1'b0,    0,     0,    0,     0};
    tbl[4] = '{1'b1, -4096, 1000, -4096, 5096};
    tbl[5] = '{1'b1, 8192,     0, 6144, -6144};
    tbl[6] = '{1'b1,    1,     0, 4097, -4097};
    tbl[7] = '{1'b1,    3,     0,    4,    -4};
    tbl[8] = '{1'b1,   -3,     0,   -1,     1};

    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    for (int i = 0; i < N; i++) rdchk("rst_weight", i, 0);

    // static filter
    wr(0, 4096);
    wr(1, 2048);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].sv, tbl[i].x, tbl[i].d, tbl[i].ey, tbl[i].ee);
      step();
    end
    drain();
    chk("static_sat_flag", int'(sat_flag), 0);

    // LMS: back-to-back samples, second sees the first update immediately
    do_reset();
    mode = 2'd0; gamma = 16'sd2048; training_en = 1'b1;
    drive(1'b1, 4096, 4096, 0, 4096);
    step();
    drive(1'b1, 4096, 4096, 2048, 2048);
    step();
    rdchk("lms_w0_e1", 0, 2048);
    rdchk("lms_w1_e1", 1, 0);
    s_valid = 1'b0;
    step();
    rdchk("lms_w0_e2", 0, 3072);
    rdchk("lms_w1_e2", 1, 1024);
    rdchk("lms_w2_e2", 2, 0);
    drain();

    // sign-error: negative error negates the step
    do_reset();
    mode = 2'd1;
    drive(1'b1, 4096, -4096, 0, -4096);
    step();
    s_valid = 1'b0;
    step();
    rdchk("serr_w0", 0, -2048);
    drain();

    // saturation and sticky flag
    do_reset();
    training_en = 1'b0;
    wr(0, 32767);
    drive(1'b1, 32767, 0, 32767, -32767);
    step();
    s_valid = 1'b0;
    step();
    chk("sat_set", int'(sat_flag), 1);
    step();
    chk("sat_hold", int'(sat_flag), 1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_cleared", int'(sat_flag), 0);
    drive(1'b1, 32767, 0, 32767, -32767);
    step();
    s_valid = 1'b0;
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_set_beats_clr", int'(sat_flag), 1);
    drain();

    // sign-sign: taps x0=-4096, x1=0, x2=4096, err<0
    do_reset();
    wr(2, 1000);
    mode = 2'd2; gamma = 16'sd16; training_en = 1'b0;
    drive(1'b1, 4096, 0, 0, 0);      step(); s_valid = 1'b0; step();
    drive(1'b1, 0, 0, 0, 0);         step(); s_valid = 1'b0; step();
    drive(1'b1, -4096, 0, 1000, -1000);
    step();
    s_valid = 1'b0; training_en = 1'b1;
    step();
    training_en = 1'b0;
    rdchk("ss_w2", 2, 984);
    rdchk("ss_w0", 0, 16);
    rdchk("ss_w1_zero_tap", 1, 0);
    drain();

    // host write collides with an adaptive update on index 0
    do_reset();
    mode = 2'd0; gamma = 16'sd2048;
    drive(1'b1, 4096, 0, 0, 0);
    step();
    drive(1'b1, 4096, 4096, 0, 4096);
    step();
    s_valid = 1'b0; training_en = 1'b1;
    w_wr_en = 1'b1; w_wr_addr = 3'd0; w_wr_data = 16'sd777;
    step();
    w_wr_en = 1'b0; training_en = 1'b0;
    rdchk("coll_w0", 0, 777);
    rdchk("coll_w1", 1, 2048);
    rdchk("coll_w2", 2, 0);
    chk("coll_sat_flag", int'(sat_flag), 0);
    drain();

    // reset mid-stream
    do_reset();
    wr(0, 32767);
    drive(1'b1, 32767, 0, 32767, -32767);
    step();
    drive(1'b1, 0, 0, 0, 0);
    step();
    chk("mid_m_valid", int'(m_valid), 1);
    chk("mid_sat_flag", int'(sat_flag), 1);
    #2;
    Rst = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("arst_m_valid", int'(m_valid), 0);
    chk("arst_y_out", int'(y_out), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_sat_flag", int'(sat_flag), 0);
    for (int i = 0; i < N; i++) rdchk("arst_weight", i, 0);
    sbq.delete();
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    step();
    chk("post_rst_idle", int'(m_valid), 0);
    drive(1'b1, 100, 123, 0, 123);
    step();
    chk("lat_edge0", int'(m_valid), 0);
    s_valid = 1'b0;
    step();
    chk("lat_edge1", int'(m_valid), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
